// File: rtl/freq_display_driver.sv
// freq_display_driver
// Takes the 12-bit frequency reading (0-4095 Hz) and converts it to four BCD
// digits with a sequential shift-add-3 (double-dabble) FSM. The digits are
// time-multiplexed onto a 4-digit common-anode 7-segment display, where the
// segments and anodes are active-low. Leading zeros can be blanked, and the
// display only ever shows the result of the last completed conversion.

module freq_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] FREQ,
  output logic [15:0] BCD,
  output logic        BUSY,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t      state;
  logic [27:0] shift_reg;
  logic [27:0] adjusted;
  logic [11:0] last_conv;
  logic [3:0]  bit_cnt;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       digit_nib;
  logic [6:0]       seg_dec;
  logic             blank_slot;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
  always_comb begin
    adjusted = shift_reg;
    for (int n = 0; n < 4; n++) begin
      if (shift_reg[12 + 4*n +: 4] >= 4'd5) begin
        adjusted[12 + 4*n +: 4] = shift_reg[12 + 4*n +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: start when FREQ differs from the last value converted,
  // do 12 shift iterations, then publish the whole BCD result in one step
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      last_conv <= '0;
      bit_cnt   <= '0;
      BCD       <= '0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (FREQ != last_conv) begin
            shift_reg <= {16'b0, FREQ};
            last_conv <= FREQ;
            bit_cnt   <= '0;
            BUSY      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= adjusted << 1;
          bit_cnt   <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          BCD   <= shift_reg[27:12];
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Refresh timer: after REFRESH_DIV cycles, advance to the next digit slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Select the current digit and decide whether it is a leading zero to blank
  always_comb begin
    digit_nib  = BCD[3:0];
    blank_slot = 1'b0;
    case (digit_idx)
      2'd0: begin
        digit_nib  = BCD[3:0];
        blank_slot = 1'b0;
      end
      2'd1: begin
        digit_nib  = BCD[7:4];
        blank_slot = BLANK_LZ && (BCD[15:4] == 12'd0);
      end
      2'd2: begin
        digit_nib  = BCD[11:8];
        blank_slot = BLANK_LZ && (BCD[15:8] == 8'd0);
      end
      2'd3: begin
        digit_nib  = BCD[15:12];
        blank_slot = BLANK_LZ && (BCD[15:12] == 4'd0);
      end
      default: begin
        digit_nib  = BCD[3:0];
        blank_slot = 1'b0;
      end
    endcase
  end

  // Seven-segment decode {g,f,e,d,c,b,a}, active-low; non-decimal codes go dark
  always_comb begin
    seg_dec = 7'h7F;
    case (digit_nib)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Register anode and segment drive so the display lines stay glitch-free
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= 4'hF;
      SEG <= 7'h7F;
    end else if (blank_slot) begin
      AN  <= 4'hF;
      SEG <= 7'h7F;
    end else begin
      AN  <= ~(4'b0001 << digit_idx);
      SEG <= seg_dec;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_freq_display_driver.sv
// tb_freq_display_driver
// Directed testbench for freq_display_driver. The refresh divider is set to 4
// so that a whole display frame fits in 16 cycles.

module tb_freq_display_driver;

  logic        CLK;
  logic        RST;
  logic [11:0] FREQ;
  logic [15:0] BCD;
  logic        BUSY;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int checks;
  int errors;

  freq_display_driver #(
    .REFRESH_DIV(4),
    .BLANK_LZ(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .FREQ(FREQ),
    .BCD(BCD),
    .BUSY(BUSY),
    .AN(AN),
    .SEG(SEG),
    .DP(DP)
  );

  // 100 MHz clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock edge and settle 1 ns after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Apply a new FREQ, then count how many sampled cycles BUSY stays high (bounded)
  task automatic applyStimulus(input logic [11:0] f, output int n);
    FREQ = f;
    n = 0;
    step();
    while (BUSY && n < 40) begin
      n++;
      step();
    end
  endtask

  // Wait for the first cycle of digit slot 0 (AN becoming E), bounded
  task automatic wait_slot0(output bit found);
    logic [3:0] prev;
    found = 1'b0;
    prev = AN;
    for (int i = 0; i < 40; i++) begin
      step();
      if (AN == 4'hE && prev != 4'hE) begin
        found = 1'b1;
        break;
      end
      prev = AN;
    end
  endtask

  task automatic test_reset();
    bit busy_seen;
    RST = 1'b1;
    FREQ = 12'd0;
    repeat (3) step();
    checks++; if (BCD !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd: got %h want 0000", BCD); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (AN !== 4'hF) begin errors++; $display("[TB] FAIL reset_an: got %h want F", AN); end
    checks++; if (SEG !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg: got %h want 7F", SEG); end
    checks++; if (DP !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b want 1", DP); end
    RST = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      step();
      if (BUSY !== 1'b0) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_conv: busy rose=%b want 0", busy_seen); end
  endtask

  task automatic test_convert_1234();
    int n;
    bit partial;
    bit busy_seen;
    FREQ = 12'd1234;
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL conv1234_busy_rise: got %b want 1", BUSY); end
    n = 1;
    partial = 1'b0;
    while (n < 40) begin
      step();
      if (!BUSY) break;
      n++;
      if (BCD !== 16'h0000) partial = 1'b1;
    end
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL conv1234_busy_len: got %0d want 13", n); end
    checks++; if (partial !== 1'b0) begin errors++; $display("[TB] FAIL conv1234_partial: bcd changed while busy=%b want 0", partial); end
    checks++; if (BCD !== 16'h1234) begin errors++; $display("[TB] FAIL conv1234_bcd: got %h want 1234", BCD); end
    busy_seen = 1'b0;
    repeat (20) begin
      step();
      if (BUSY !== 1'b0) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL conv1234_unchanged: busy rose=%b want 0", busy_seen); end
  endtask

  task automatic test_display_4095();
    int n;
    bit found;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{7'h12, 7'h10, 7'h40, 7'h19};
    applyStimulus(12'd4095, n);
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL conv4095_busy_len: got %0d want 13", n); end
    checks++; if (BCD !== 16'h4095) begin errors++; $display("[TB] FAIL conv4095_bcd: got %h want 4095", BCD); end
    wait_slot0(found);
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL disp4095_slot0: found=%b want 1", found); end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (AN !== exp_an[s]) begin errors++; $display("[TB] FAIL disp4095_an slot%0d cyc%0d: got %h want %h", s, c, AN, exp_an[s]); end
        checks++; if (SEG !== exp_seg[s]) begin errors++; $display("[TB] FAIL disp4095_seg slot%0d cyc%0d: got %h want %h", s, c, SEG, exp_seg[s]); end
        step();
      end
    end
  endtask

  task automatic test_blanking(input logic [11:0] f, input logic [15:0] exp_bcd, input logic [6:0] seg0);
    int n;
    bit found;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an  = '{4'hE, 4'hF, 4'hF, 4'hF};
    exp_seg = '{seg0, 7'h7F, 7'h7F, 7'h7F};
    applyStimulus(f, n);
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL blank%0d_busy_len: got %0d want 13", f, n); end
    checks++; if (BCD !== exp_bcd) begin errors++; $display("[TB] FAIL blank%0d_bcd: got %h want %h", f, BCD, exp_bcd); end
    wait_slot0(found);
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL blank%0d_slot0: found=%b want 1", f, found); end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (AN !== exp_an[s]) begin errors++; $display("[TB] FAIL blank%0d_an slot%0d cyc%0d: got %h want %h", f, s, c, AN, exp_an[s]); end
        checks++; if (SEG !== exp_seg[s]) begin errors++; $display("[TB] FAIL blank%0d_seg slot%0d cyc%0d: got %h want %h", f, s, c, SEG, exp_seg[s]); end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    FREQ = 12'd100;
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_rise: got %b want 1", BUSY); end
    repeat (4) step();
    FREQ = 12'd250;
    n = 5;
    while (BUSY && n < 40) begin
      step();
      if (BUSY) n++;
    end
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL b2b_first_len: got %0d want 13", n); end
    checks++; if (BCD !== 16'h0100) begin errors++; $display("[TB] FAIL b2b_first_bcd: got %h want 0100", BCD); end
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart: got %b want 1", BUSY); end
    n = 1;
    while (BUSY && n < 40) begin
      step();
      if (BUSY) n++;
    end
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL b2b_second_len: got %0d want 13", n); end
    checks++; if (BCD !== 16'h0250) begin errors++; $display("[TB] FAIL b2b_second_bcd: got %h want 0250", BCD); end
  endtask

  task automatic test_reset_abort();
    int n;
    FREQ = 12'd999;
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_rise: got %b want 1", BUSY); end
    repeat (5) step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_6th: got %b want 1", BUSY); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (BCD !== 16'h0000) begin errors++; $display("[TB] FAIL abort_bcd: got %h want 0000", BCD); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", BUSY); end
    checks++; if (AN !== 4'hF) begin errors++; $display("[TB] FAIL abort_an: got %h want F", AN); end
    checks++; if (SEG !== 7'h7F) begin errors++; $display("[TB] FAIL abort_seg: got %h want 7F", SEG); end
    applyStimulus(12'd999, n);
    checks++; if (n != 13) begin errors++; $display("[TB] FAIL abort_reconv_len: got %0d want 13", n); end
    checks++; if (BCD !== 16'h0999) begin errors++; $display("[TB] FAIL abort_reconv_bcd: got %h want 0999", BCD); end
  endtask

  // Run every scenario in order and print the summary line
  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    FREQ = 12'd0;
    test_reset();
    test_convert_1234();
    test_display_4095();
    test_blanking(12'd7, 16'h0007, 7'h78);
    test_back_to_back();
    test_reset_abort();
    test_blanking(12'd0, 16'h0000, 7'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
